// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
//
// Shares one single-port, word-organised data memory (1-cycle read latency)
// between two requesters: port 0 is the CPU MEM stage and port 1 is the
// debug/DMA master. The arbiter works round-robin. It turns byte/half/word
// operations into byte-lane enables and lane-replicated write data. It also
// sign- or zero-extends the data returned by loads.
//
// Optional feature (compile-time macro DM_ARB_LOCK_EN):
//   When this macro is defined, the inputs p0_lock/p1_lock are added. A
//   request granted with lock=1 pins the arbiter to that port until the same
//   port is granted a request with lock=0.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   pN_req/we/size/unsigned/addr/wdata
//                         request from port N (fields held until pN_gnt)
//   pN_lock               (DM_ARB_LOCK_EN only) lock request for port N
//   pN_gnt                access accepted this cycle (combinational)
//   pN_rvalid/pN_rdata    load response, one cycle after the grant
//   pN_err                misaligned/illegal request, one cycle after grant
//   mem_en/we/be/addr/wdata  SRAM command
//   mem_rdata             SRAM read word, valid the cycle after a read
// -----------------------------------------------------------------------------
module dm_port_arbiter #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic              p0_unsigned,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic              p1_unsigned,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p1_wdata,
`ifdef DM_ARB_LOCK_EN
  input  logic              p0_lock,
  input  logic              p1_lock,
`endif
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT_P0  = 3'd1,
    GRANT_P1  = 3'd2
`ifdef DM_ARB_LOCK_EN
    ,
    LOCKED_P0 = 3'd3,
    LOCKED_P1 = 3'd4
`endif
  } state_t;

  state_t      state, next_state;
  logic        rr_hist, last_granted;
  logic        rr_pick0, rr_pick1;
  logic        gnt0, gnt1, any_gnt;
  logic        sel_we, sel_uns;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;
  logic        legal, access;
  logic [3:0]  lane_mask;
  logic        rd_pending, rd_owner, rd_uns;
  logic [1:0]  rd_off, rd_size;
  logic        err0_q, err1_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic [31:0] rd_lane, load_ext;
  logic        unused_addr_bits;

  // The state only remembers last cycle's grant. When the arbiter is idle,
  // rr_hist carries the pointer forward so that it survives idle gaps.
  always_comb begin
    last_granted = rr_hist;
    case (state)
      GRANT_P0:  last_granted = 1'b0;
      GRANT_P1:  last_granted = 1'b1;
`ifdef DM_ARB_LOCK_EN
      LOCKED_P0: last_granted = 1'b0;
      LOCKED_P1: last_granted = 1'b1;
`endif
      default:   ;
    endcase
  end

  // Port 1 wins when it is the only requester, or on a conflict if port 0
  // was the last port served.
  assign rr_pick1 = p1_req & (~p0_req | ~last_granted);
  assign rr_pick0 = p0_req & ~rr_pick1;

  // Grant selection and next-state logic. Grants are held low during reset.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    next_state = IDLE;
`ifdef DM_ARB_LOCK_EN
    if (state == LOCKED_P0) begin
      gnt0 = p0_req;
    end else if (state == LOCKED_P1) begin
      gnt1 = p1_req;
    end else begin
      gnt0 = rr_pick0;
      gnt1 = rr_pick1;
    end
`else
    gnt0 = rr_pick0;
    gnt1 = rr_pick1;
`endif
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
`ifdef DM_ARB_LOCK_EN
    if (gnt0) begin
      next_state = p0_lock ? LOCKED_P0 : GRANT_P0;
    end else if (gnt1) begin
      next_state = p1_lock ? LOCKED_P1 : GRANT_P1;
    end else if (state == LOCKED_P0 || state == LOCKED_P1) begin
      next_state = state;
    end
`else
    if (gnt0) begin
      next_state = GRANT_P0;
    end else if (gnt1) begin
      next_state = GRANT_P1;
    end
`endif
  end

  // State register; after reset, port 1 counts as the last port granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_hist <= 1'b1;
    end else begin
      state   <= next_state;
      rr_hist <= last_granted;
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel_we    = gnt1 ? p1_we       : p0_we;
  assign sel_uns   = gnt1 ? p1_unsigned : p0_unsigned;
  assign sel_size  = gnt1 ? p1_size     : p0_size;
  assign sel_addr  = gnt1 ? p1_addr     : p0_addr;
  assign sel_wdata = gnt1 ? p1_wdata    : p0_wdata;

  // Alignment check and byte-lane mask for the selected request.
  always_comb begin
    legal     = 1'b0;
    lane_mask = 4'b0000;
    case (sel_size)
      2'b00: begin
        legal     = 1'b1;
        lane_mask = 4'b0001 << sel_addr[1:0];
      end
      2'b01: begin
        legal     = ~sel_addr[0];
        lane_mask = 4'b0011 << sel_addr[1:0];
      end
      2'b10: begin
        legal     = (sel_addr[1:0] == 2'b00);
        lane_mask = 4'b1111;
      end
      default: ;
    endcase
  end

  assign access   = any_gnt & legal;
  assign mem_en   = access;
  assign mem_we   = access & sel_we;
  assign mem_be   = access ? lane_mask : 4'b0000;
  assign mem_addr = sel_addr[MEM_AW+1:2];

  // Store data is replicated across the word so that every enabled lane
  // sees the right bytes, whatever the address offset.
  always_comb begin
    mem_wdata = 32'h0;
    if (access & sel_we) begin
      case (sel_size)
        2'b00:   mem_wdata = {4{sel_wdata[7:0]}};
        2'b01:   mem_wdata = {2{sel_wdata[15:0]}};
        default: mem_wdata = sel_wdata;
      endcase
    end
  end

  assign unused_addr_bits = ^sel_addr[31:MEM_AW+2];

  // Response tracking: the load context is registered at grant time, and
  // error flags are raised the cycle after an illegal grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
      rd_off     <= 2'b00;
      rd_size    <= 2'b00;
      rd_uns     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
    end else begin
      rd_pending <= access & ~sel_we;
      if (access & ~sel_we) begin
        rd_owner <= gnt1;
        rd_off   <= sel_addr[1:0];
        rd_size  <= sel_size;
        rd_uns   <= sel_uns;
      end
      err0_q <= gnt0 & ~legal;
      err1_q <= gnt1 & ~legal;
      if (rd_pending & ~rd_owner) rdata0_q <= load_ext;
      if (rd_pending & rd_owner)  rdata1_q <= load_ext;
    end
  end

  // Move the addressed lane down to bit 0, then extend it.
  assign rd_lane = mem_rdata >> {rd_off, 3'b000};

  always_comb begin
    case (rd_size)
      2'b00:   load_ext = {{24{~rd_uns & rd_lane[7]}},  rd_lane[7:0]};
      2'b01:   load_ext = {{16{~rd_uns & rd_lane[15]}}, rd_lane[15:0]};
      default: load_ext = rd_lane;
    endcase
  end

  // Responses are masked during reset, so a read that was pending when
  // reset arrived never produces an rvalid.
  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_rvalid = ~reset & rd_pending & ~rd_owner;
  assign p1_rvalid = ~reset & rd_pending & rd_owner;
  assign p0_err    = ~reset & err0_q;
  assign p1_err    = ~reset & err1_q;
  assign p0_rdata  = reset ? 32'h0 : (p0_rvalid ? load_ext : rdata0_q);
  assign p1_rdata  = reset ? 32'h0 : (p1_rvalid ? load_ext : rdata1_q);

endmodule

// File: tb/tb_dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_port_arbiter
//
// Self-checking bench for dm_port_arbiter. A behavioural SRAM is attached to
// the memory port. A byte-addressed reference memory plus a simple grant
// model predict grants, lane enables, write data, load results and errors.
// Define DM_ARB_LOCK_EN to also exercise the lock ports.
// -----------------------------------------------------------------------------
module tb_dm_port_arbiter;

  localparam int MEM_AW = 10;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lock;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  logic p0_req, p0_we, p0_unsigned, p1_req, p1_we, p1_unsigned;
  logic [1:0]  p0_size, p1_size;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
`ifdef DM_ARB_LOCK_EN
  logic p0_lock, p1_lock;
`endif
  logic p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic mem_en, mem_we;
  logic [3:0] mem_be;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] sram [0:(1<<MEM_AW)-1];
  logic [7:0]  ref_mem [0:(4<<MEM_AW)-1];

  int n_vec = 0;
  int n_mis = 0;

  // model state
  int          m_last;
  int          m_lock;
  logic [31:0] m_hold0, m_hold1;
  logic        m_g0, m_g1;
  logic        e_rv0, e_rv1, e_err0, e_err1;
  logic [31:0] e_rd0, e_rd1;
  logic [17:0] exp_issue, obs_issue;
  logic        chk_wdata;
  logic [31:0] exp_wdata;
  logic [67:0] exp_resp, obs_resp;

  dm_port_arbiter #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_unsigned(p0_unsigned),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_unsigned(p1_unsigned),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
`ifdef DM_ARB_LOCK_EN
    .p0_lock(p0_lock), .p1_lock(p1_lock),
`endif
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM with one-cycle read latency; cleared while reset is high.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < (1<<MEM_AW); i++) sram[i] <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  function automatic req_t mk_req(input logic r, input logic we, input logic [1:0] sz,
                                  input logic u, input logic [31:0] a,
                                  input logic [31:0] wd, input logic lk);
    req_t q;
    q.req = r; q.we = we; q.size = sz; q.uns = u; q.addr = a; q.wdata = wd; q.lock = lk;
    return q;
  endfunction

  task model_reset;
    m_last  = 1;
    m_lock  = -1;
    m_hold0 = 32'h0;
    m_hold1 = 32'h0;
    e_rv0 = 0; e_rv1 = 0; e_err0 = 0; e_err1 = 0;
    e_rd0 = 32'h0; e_rd1 = 32'h0;
    for (int i = 0; i < (4<<MEM_AW); i++) ref_mem[i] = 8'h00;
  endtask

  // Drive both ports, let combinational outputs settle, capture them and
  // predict this cycle's command plus the next cycle's response.
  task issue(input req_t q0, input req_t q1);
    req_t w;
    int nbytes, off, idx, be_i;
    logic legal_m, acc_m;
    logic [31:0] val;
    p0_req = q0.req; p0_we = q0.we; p0_size = q0.size; p0_unsigned = q0.uns;
    p0_addr = q0.addr; p0_wdata = q0.wdata;
    p1_req = q1.req; p1_we = q1.we; p1_size = q1.size; p1_unsigned = q1.uns;
    p1_addr = q1.addr; p1_wdata = q1.wdata;
`ifdef DM_ARB_LOCK_EN
    p0_lock = q0.lock; p1_lock = q1.lock;
`endif
    #2;
    obs_issue = {p0_gnt, p1_gnt, mem_en, mem_we, mem_be, mem_en ? mem_addr : 10'd0};
    m_g0 = 0; m_g1 = 0;
    if (m_lock == 0) m_g0 = q0.req;
    else if (m_lock == 1) m_g1 = q1.req;
    else if (q0.req && q1.req) begin
      if (m_last == 1) m_g0 = 1; else m_g1 = 1;
    end else begin
      m_g0 = q0.req; m_g1 = q1.req;
    end
    w       = m_g1 ? q1 : q0;
    nbytes  = 1 << w.size;
    off     = int'(w.addr % 4);
    idx     = int'(w.addr % (4 << MEM_AW));
    legal_m = (w.size != 2'd3) && ((w.addr % nbytes) == 0);
    acc_m   = (m_g0 || m_g1) && legal_m;
    be_i    = acc_m ? (((1 << nbytes) - 1) << off) : 0;
    exp_issue = {m_g0, m_g1, acc_m, acc_m && w.we, be_i[3:0],
                 acc_m ? w.addr[MEM_AW+1:2] : 10'd0};
    chk_wdata = acc_m && w.we;
    if (w.size == 2'd0)      exp_wdata = w.wdata[7:0] * 32'h01010101;
    else if (w.size == 2'd1) exp_wdata = w.wdata[15:0] * 32'h00010001;
    else                     exp_wdata = w.wdata;
    val = 32'h0;
    if (acc_m && w.we) begin
      for (int i = 0; i < nbytes; i++) ref_mem[idx+i] = 8'(w.wdata >> (8*i));
    end else if (acc_m) begin
      for (int i = 0; i < nbytes; i++) val = val | (32'(ref_mem[idx+i]) << (8*i));
      if (!w.uns && nbytes < 4 && val[8*nbytes-1]) val = val - (32'd1 << (8*nbytes));
    end
    e_rv0  = acc_m && !w.we && m_g0;
    e_rv1  = acc_m && !w.we && m_g1;
    e_err0 = m_g0 && !legal_m;
    e_err1 = m_g1 && !legal_m;
    e_rd0  = e_rv0 ? val : m_hold0;
    e_rd1  = e_rv1 ? val : m_hold1;
    m_hold0 = e_rd0;
    m_hold1 = e_rd1;
    if (m_g0 || m_g1) begin
      m_last = m_g1 ? 1 : 0;
      m_lock = w.lock ? m_last : -1;
    end
  endtask

  task respond;
    @(posedge clk); #1;
    obs_resp = {p0_rvalid, p1_rvalid, p0_err, p1_err, p0_rdata, p1_rdata};
    exp_resp = {e_rv0, e_rv1, e_err0, e_err1, e_rd0, e_rd1};
  endtask

  task do_reset;
    reset = 1;
    issue(mk_req(0,0,0,0,0,0,0), mk_req(0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task test_reset;
    reset = 1;
    p0_req = 1; p0_we = 1; p0_size = 2; p0_unsigned = 0; p0_addr = 32'h10; p0_wdata = 32'h1;
    p1_req = 1; p1_we = 0; p1_size = 2; p1_unsigned = 0; p1_addr = 32'h20; p1_wdata = 32'h2;
`ifdef DM_ARB_LOCK_EN
    p0_lock = 0; p1_lock = 0;
`endif
    @(posedge clk); #3;
    n_vec++;
    if ({p0_gnt, p1_gnt, mem_en, mem_we, mem_be} !== 8'h00) begin
      n_mis++;
      $display("[TB] FAIL reset_cmd: got %b expected 00000000", {p0_gnt, p1_gnt, mem_en, mem_we, mem_be});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({p0_rvalid, p1_rvalid, p0_err, p1_err, p0_rdata, p1_rdata} !== 68'h0) begin
      n_mis++;
      $display("[TB] FAIL reset_resp: got %h expected 0",
               {p0_rvalid, p1_rvalid, p0_err, p1_err, p0_rdata, p1_rdata});
    end
    p0_req = 0; p1_req = 0;
    reset = 0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task test_word;
    req_t ops [2];
    ops[0] = mk_req(1,1,2'd2,0,32'h10,32'h12345678,0);
    ops[1] = mk_req(1,0,2'd2,0,32'h10,32'h0,0);
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], mk_req(0,0,0,0,0,0,0));
      n_vec++;
      if (obs_issue !== exp_issue) begin
        n_mis++; $display("[TB] FAIL word_cmd[%0d]: got %h expected %h", i, obs_issue, exp_issue);
      end
      if (i == 0) begin
        n_vec++;
        if (mem_be !== 4'b1111 || mem_addr !== 10'd4 || mem_wdata !== 32'h12345678) begin
          n_mis++;
          $display("[TB] FAIL word_store: be=%b addr=%0d wdata=%h expected 1111 4 12345678",
                   mem_be, mem_addr, mem_wdata);
        end
      end
      respond();
      n_vec++;
      if (obs_resp !== exp_resp) begin
        n_mis++; $display("[TB] FAIL word_resp[%0d]: got %h expected %h", i, obs_resp, exp_resp);
      end
    end
    n_vec++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h12345678) begin
      n_mis++; $display("[TB] FAIL word_load: rvalid=%b rdata=%h expected 1 12345678", p0_rvalid, p0_rdata);
    end
  endtask

  task test_byte_ext;
    req_t ops [3];
    logic [31:0] want [3];
    ops[0] = mk_req(1,1,2'd0,0,32'h13,32'h00000080,0);
    ops[1] = mk_req(1,0,2'd0,0,32'h13,32'h0,0);
    ops[2] = mk_req(1,0,2'd0,1,32'h13,32'h0,0);
    want[1] = 32'hFFFFFF80;
    want[2] = 32'h00000080;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], mk_req(0,0,0,0,0,0,0));
      n_vec++;
      if (obs_issue !== exp_issue) begin
        n_mis++; $display("[TB] FAIL byte_cmd[%0d]: got %h expected %h", i, obs_issue, exp_issue);
      end
      if (chk_wdata) begin
        n_vec++;
        if (mem_wdata !== exp_wdata || mem_be !== 4'b1000 || mem_wdata !== 32'h80808080) begin
          n_mis++;
          $display("[TB] FAIL byte_store: be=%b wdata=%h expected 1000 80808080", mem_be, mem_wdata);
        end
      end
      respond();
      n_vec++;
      if (obs_resp !== exp_resp) begin
        n_mis++; $display("[TB] FAIL byte_resp[%0d]: got %h expected %h", i, obs_resp, exp_resp);
      end
      if (i > 0) begin
        n_vec++;
        if (p0_rdata !== want[i]) begin
          n_mis++; $display("[TB] FAIL byte_ext[%0d]: got %h expected %h", i, p0_rdata, want[i]);
        end
      end
    end
  endtask

  task test_alternate;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      issue(mk_req(1,0,2'd2,0,32'h10,0,0), mk_req(1,0,2'd0,1,32'h13,0,0));
      n_vec++;
      if (obs_issue !== exp_issue || p0_gnt !== (i % 2 == 0)) begin
        n_mis++; $display("[TB] FAIL alt_cmd[%0d]: got %h expected %h", i, obs_issue, exp_issue);
      end
      respond();
      n_vec++;
      if (obs_resp !== exp_resp) begin
        n_mis++; $display("[TB] FAIL alt_resp[%0d]: got %h expected %h", i, obs_resp, exp_resp);
      end
    end
  endtask

  task test_illegal;
    req_t ops [3];
    ops[0] = mk_req(1,0,2'd2,0,32'h02,0,0);
    ops[1] = mk_req(1,1,2'd3,0,32'h00,32'hDEADBEEF,0);
    ops[2] = mk_req(1,0,2'd2,0,32'h00,0,0);
    for (int i = 0; i < 3; i++) begin
      issue(mk_req(0,0,0,0,0,0,0), ops[i]);
      n_vec++;
      if (obs_issue !== exp_issue) begin
        n_mis++; $display("[TB] FAIL illegal_cmd[%0d]: got %h expected %h", i, obs_issue, exp_issue);
      end
      respond();
      n_vec++;
      if (obs_resp !== exp_resp || (i < 2 && p1_err !== 1'b1)) begin
        n_mis++; $display("[TB] FAIL illegal_resp[%0d]: got %h expected %h", i, obs_resp, exp_resp);
      end
    end
    n_vec++;
    if (sram[0] !== {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]}) begin
      n_mis++;
      $display("[TB] FAIL illegal_mem: got %h expected %h", sram[0],
               {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]});
    end
  endtask

  task test_reset_mid_read;
    issue(mk_req(1,1,2'd2,0,32'h40,32'hCAFEF00D,0), mk_req(0,0,0,0,0,0,0));
    respond();
    issue(mk_req(1,0,2'd2,0,32'h40,0,0), mk_req(0,0,0,0,0,0,0));
    n_vec++;
    if (obs_issue !== exp_issue) begin
      n_mis++; $display("[TB] FAIL rstrd_cmd: got %h expected %h", obs_issue, exp_issue);
    end
    @(posedge clk);
    reset = 1;
    p0_req = 0;
    #1;
    n_vec++;
    if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
      n_mis++; $display("[TB] FAIL rstrd_rvalid: got %b%b expected 00", p0_rvalid, p1_rvalid);
    end
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    #1;
    n_vec++;
    if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
      n_mis++; $display("[TB] FAIL rstrd_after: got %b%b expected 00", p0_rvalid, p1_rvalid);
    end
    issue(mk_req(1,0,2'd2,0,32'h40,0,0), mk_req(1,0,2'd2,0,32'h44,0,0));
    n_vec++;
    if (obs_issue !== exp_issue || p0_gnt !== 1'b1) begin
      n_mis++; $display("[TB] FAIL rstrd_conflict: got %h expected %h", obs_issue, exp_issue);
    end
    respond();
    n_vec++;
    if (obs_resp !== exp_resp) begin
      n_mis++; $display("[TB] FAIL rstrd_resp: got %h expected %h", obs_resp, exp_resp);
    end
  endtask

`ifdef DM_ARB_LOCK_EN
  task test_lock;
    logic want_g0 [5];
    req_t p1op;
    do_reset();
    want_g0 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      p1op = mk_req(i < 4, 1, 2'd2, 0, 32'h80 + 32'(4*i), 32'h1000 + 32'(i), i < 3);
      issue(mk_req(i > 0, 0, 2'd2, 0, 32'h80, 0, 0), p1op);
      n_vec++;
      if (obs_issue !== exp_issue || p0_gnt !== want_g0[i]) begin
        n_mis++; $display("[TB] FAIL lock_cmd[%0d]: got %h expected %h", i, obs_issue, exp_issue);
      end
      respond();
      n_vec++;
      if (obs_resp !== exp_resp) begin
        n_mis++; $display("[TB] FAIL lock_resp[%0d]: got %h expected %h", i, obs_resp, exp_resp);
      end
    end
  endtask
`endif

  task test_random;
    req_t cur0, cur1;
    cur0 = mk_req(0,0,0,0,0,0,0);
    cur1 = mk_req(0,0,0,0,0,0,0);
    for (int i = 0; i < 400; i++) begin
      if (!cur0.req || m_g0) begin
        cur0.req   = ($urandom_range(0,3) != 0);
        cur0.we    = 1'($urandom);
        cur0.size  = ($urandom_range(0,15) == 0) ? 2'd3 : 2'($urandom_range(0,2));
        cur0.uns   = 1'($urandom);
        cur0.addr  = 32'($urandom_range(0,15) * 4) + (($urandom_range(0,1) == 0) ? 32'd0 : 32'($urandom_range(0,3)));
        cur0.wdata = $urandom;
        cur0.lock  = 1'b0;
      end
      if (!cur1.req || m_g1) begin
        cur1.req   = ($urandom_range(0,3) != 0);
        cur1.we    = 1'($urandom);
        cur1.size  = ($urandom_range(0,15) == 0) ? 2'd3 : 2'($urandom_range(0,2));
        cur1.uns   = 1'($urandom);
        cur1.addr  = 32'($urandom_range(0,15) * 4) + (($urandom_range(0,1) == 0) ? 32'd0 : 32'($urandom_range(0,3)));
        cur1.wdata = $urandom;
        cur1.lock  = 1'b0;
      end
      issue(cur0, cur1);
      n_vec++;
      if (obs_issue !== exp_issue) begin
        n_mis++; $display("[TB] FAIL rand_cmd[%0d]: got %h expected %h", i, obs_issue, exp_issue);
      end
      if (chk_wdata) begin
        n_vec++;
        if (mem_wdata !== exp_wdata) begin
          n_mis++; $display("[TB] FAIL rand_wdata[%0d]: got %h expected %h", i, mem_wdata, exp_wdata);
        end
      end
      respond();
      n_vec++;
      if (obs_resp !== exp_resp) begin
        n_mis++; $display("[TB] FAIL rand_resp[%0d]: got %h expected %h", i, obs_resp, exp_resp);
      end
    end
  endtask

  initial begin
    mem_rdata = 32'h0;
    model_reset();
    test_reset();
    test_word();
    test_byte_ext();
    test_alternate();
    test_illegal();
    test_reset_mid_read();
`ifdef DM_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
